// File: rtl/bisr_pkg.sv
// Shared types for the BISR recompute path: dispatch FSM states and index-width helpers.
package bisr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ISSUE,
        DONE
    } dispatch_state_t;

    localparam int DEF_ROWS      = 3;
    localparam int DEF_COLS      = 3;
    localparam int DEF_WORD_SIZE = 16;
    localparam int DEF_CELLS     = DEF_ROWS * DEF_COLS;

    // Width of a binary index into n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fault_map_regfile.sv
// Fault bitmap and shadow PE weights, written by (row, col) and read by row-major cell index.
// Optional FAULT_COUNT_EN adds a registered popcount of the map.
module fault_map_regfile
    import bisr_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fault_we,
    input  logic                             map_clear,
    input  logic                             weight_we,
    input  logic [idx_w(ROWS)-1:0]           wr_row,
    input  logic [idx_w(COLS)-1:0]           wr_col,
    input  logic [WORD_SIZE-1:0]             weight_data,
    input  logic [idx_w(ROWS*COLS)-1:0]      rd_idx,
`ifdef FAULT_COUNT_EN
    output logic [$clog2(ROWS*COLS+1)-1:0]   fault_count,
`endif
    output logic                             rd_fault,
    output logic [WORD_SIZE-1:0]             rd_weight
);

    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = idx_w(CELLS);

    logic [CELLS-1:0]     fault_q, fault_d;
    logic [WORD_SIZE-1:0] weight_q [CELLS];
    logic [WORD_SIZE-1:0] weight_d [CELLS];
    logic                 wr_ok;
    logic [IDX_W-1:0]     wr_idx;

    always_comb begin
        wr_ok    = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
        wr_idx   = IDX_W'(32'(wr_row) * COLS + 32'(wr_col));
        fault_d  = fault_q;
        weight_d = weight_q;
        // Clear beats a same-cycle set so a fresh diagnosis always starts from an empty map.
        if (map_clear) begin
            fault_d = '0;
        end else if (fault_we && wr_ok) begin
            fault_d[wr_idx] = 1'b1;
        end
        if (weight_we && wr_ok) begin
            weight_d[wr_idx] = weight_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= '0;
            for (int i = 0; i < CELLS; i++) begin
                weight_q[i] <= '0;
            end
        end else begin
            fault_q  <= fault_d;
            weight_q <= weight_d;
        end
    end

    assign rd_fault  = fault_q[rd_idx];
    assign rd_weight = weight_q[rd_idx];

`ifdef FAULT_COUNT_EN
    localparam int CNT_W = $clog2(CELLS + 1);

    logic [CNT_W-1:0] fault_count_q, fault_count_d;

    // Counting the next map keeps the count aligned with the bits it describes.
    always_comb begin
        fault_count_d = '0;
        for (int i = 0; i < CELLS; i++) begin
            fault_count_d = fault_count_d + CNT_W'(fault_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_count_q <= '0;
        end else begin
            fault_count_q <= fault_count_d;
        end
    end

    assign fault_count = fault_count_q;
`endif

endmodule

// File: rtl/recompute_dispatcher.sv
// Walks the fault map row-major and issues one recompute job per faulty PE over valid/ready.
// Optional FAULT_COUNT_EN exposes fault_count, the popcount of the fault map.
module recompute_dispatcher
    import bisr_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fault_we,
    input  logic [idx_w(ROWS)-1:0]           fault_row,
    input  logic [idx_w(COLS)-1:0]           fault_col,
    input  logic                             map_clear,
    input  logic                             weight_we,
    input  logic [WORD_SIZE-1:0]             weight_data,
    input  logic [ROWS*WORD_SIZE-1:0]        act_in,
    input  logic                             start,
    input  logic                             issue_ready,
    output logic                             issue_valid,
    output logic [ROWS-1:0]                  faultyRowOut,
    output logic [COLS-1:0]                  faultyColOut,
    output logic [WORD_SIZE-1:0]             WeightOut,
    output logic [WORD_SIZE-1:0]             LeftOut,
    output logic                             busy,
`ifdef FAULT_COUNT_EN
    output logic [$clog2(ROWS*COLS+1)-1:0]   fault_count,
`endif
    output logic                             done
);

    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = idx_w(CELLS);
    localparam int ROW_W = idx_w(ROWS);
    localparam int COL_W = idx_w(COLS);

    dispatch_state_t      state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORD_SIZE-1:0] act_q [ROWS];
    logic [WORD_SIZE-1:0] act_d [ROWS];
    logic [ROWS-1:0]      row_oh_q, row_oh_d;
    logic [COLS-1:0]      col_oh_q, col_oh_d;
    logic [WORD_SIZE-1:0] weight_q, weight_d;
    logic [WORD_SIZE-1:0] left_q, left_d;

    logic                 rd_fault;
    logic [WORD_SIZE-1:0] rd_weight;
    logic [ROW_W-1:0]     cur_row;
    logic [COL_W-1:0]     cur_col;
    logic                 last_cell;

    fault_map_regfile #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .WORD_SIZE (WORD_SIZE)
    ) u_map (
        .clk         (clk),
        .rst         (rst),
        .fault_we    (fault_we),
        .map_clear   (map_clear),
        .weight_we   (weight_we),
        .wr_row      (fault_row),
        .wr_col      (fault_col),
        .weight_data (weight_data),
        .rd_idx      (idx_q),
`ifdef FAULT_COUNT_EN
        .fault_count (fault_count),
`endif
        .rd_fault    (rd_fault),
        .rd_weight   (rd_weight)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        act_d     = act_q;
        row_oh_d  = row_oh_q;
        col_oh_d  = col_oh_q;
        weight_d  = weight_q;
        left_d    = left_q;
        cur_row   = ROW_W'(idx_q / IDX_W'(COLS));
        cur_col   = COL_W'(idx_q % IDX_W'(COLS));
        last_cell = (idx_q == IDX_W'(CELLS - 1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int r = 0; r < ROWS; r++) begin
                        act_d[r] = act_in[r*WORD_SIZE +: WORD_SIZE];
                    end
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (rd_fault) begin
                    for (int r = 0; r < ROWS; r++) begin
                        row_oh_d[r] = (cur_row == ROW_W'(r));
                    end
                    for (int c = 0; c < COLS; c++) begin
                        col_oh_d[c] = (cur_col == COL_W'(c));
                    end
                    weight_d = rd_weight;
                    left_d   = act_q[cur_row];
                    state_d  = ISSUE;
                end else if (last_cell) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ISSUE: begin
                if (issue_ready) begin
                    if (last_cell) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            row_oh_q <= '0;
            col_oh_q <= '0;
            weight_q <= '0;
            left_q   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                act_q[r] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            row_oh_q <= row_oh_d;
            col_oh_q <= col_oh_d;
            weight_q <= weight_d;
            left_q   <= left_d;
            act_q    <= act_d;
        end
    end

    assign issue_valid  = (state_q == ISSUE);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign faultyRowOut = row_oh_q;
    assign faultyColOut = col_oh_q;
    assign WeightOut    = weight_q;
    assign LeftOut      = left_q;

endmodule

// File: tb/tb_recompute_dispatcher.sv
// Directed and randomized bench for recompute_dispatcher against a job-list reference model.
module tb_recompute_dispatcher;

    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int WS    = 16;
    localparam int CELLS = ROWS * COLS;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 fault_we;
    logic [1:0]           fault_row;
    logic [1:0]           fault_col;
    logic                 map_clear;
    logic                 weight_we;
    logic [WS-1:0]        weight_data;
    logic [ROWS*WS-1:0]   act_in;
    logic                 start;
    logic                 issue_ready;
    logic                 issue_valid;
    logic [ROWS-1:0]      faultyRowOut;
    logic [COLS-1:0]      faultyColOut;
    logic [WS-1:0]        WeightOut;
    logic [WS-1:0]        LeftOut;
    logic                 busy;
    logic                 done;
`ifdef FAULT_COUNT_EN
    logic [3:0]           fault_count;
`endif

    always #5 clk = ~clk;

    recompute_dispatcher #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS)) dut (
        .clk          (clk),
        .rst          (rst),
        .fault_we     (fault_we),
        .fault_row    (fault_row),
        .fault_col    (fault_col),
        .map_clear    (map_clear),
        .weight_we    (weight_we),
        .weight_data  (weight_data),
        .act_in       (act_in),
        .start        (start),
        .issue_ready  (issue_ready),
        .issue_valid  (issue_valid),
        .faultyRowOut (faultyRowOut),
        .faultyColOut (faultyColOut),
        .WeightOut    (WeightOut),
        .LeftOut      (LeftOut),
        .busy         (busy),
`ifdef FAULT_COUNT_EN
        .fault_count  (fault_count),
`endif
        .done         (done)
    );

    typedef struct {
        int          r;
        int          c;
        logic [WS-1:0] w;
        logic [WS-1:0] a;
    } job_t;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_fail   = 0;
    bit            mdl_f [ROWS][COLS];
    logic [WS-1:0] mdl_w [ROWS][COLS];
    logic [WS-1:0] act_v [ROWS];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ROWS*WS-1:0] pack_acts();
        logic [ROWS*WS-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*WS +: WS] = act_v[r];
        return v;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                n += int'(mdl_f[r][c]);
        return n;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                mdl_f[r][c] = 1'b0;
                mdl_w[r][c] = '0;
            end
    endtask

    // One-cycle map/weight write; the model applies the same rules from the outside.
    task automatic map_write(input bit fwe, input bit clr, input bit wwe,
                             input int r, input int c, input logic [WS-1:0] w);
        bit ok;
        fault_we    = fwe;
        map_clear   = clr;
        weight_we   = wwe;
        fault_row   = 2'(r);
        fault_col   = 2'(c);
        weight_data = w;
        @(negedge clk);
        fault_we  = 1'b0;
        map_clear = 1'b0;
        weight_we = 1'b0;
        ok = (r < ROWS) && (c < COLS);
        if (clr) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) mdl_f[i][j] = 1'b0;
        end else if (fwe && ok) mdl_f[r][c] = 1'b1;
        if (wwe && ok) mdl_w[r][c] = w;
    endtask

    // Runs one dispatch pass. stall_mode >= 0 stalls each job that many cycles, -1 stalls randomly.
    // poke pulses start, changes act_in and writes fault (0,0) mid-pass.
    task automatic run_pass(input int stall_mode, input bit poke);
        job_t          q[$];
        job_t          last;
        bit            have_last = 0;
        bit            seen_done = 0;
        int            cyc = 0;
        int            stalls = 0;
        int            jobs = 0;
        int            stall_left;
        int            first_valid = -1;
        int            first_idx = -1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mdl_f[r][c]) begin
                    q.push_back('{r, c, mdl_w[r][c], act_v[r]});
                    if (first_idx < 0) first_idx = r * COLS + c;
                end
        act_in = pack_acts();
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        stall_left = (stall_mode >= 0) ? stall_mode : int'($urandom_range(0, 3));
        while (cyc < 100) begin
            if (done) begin
                seen_done = 1;
                break;
            end
            check("busy_in_pass", busy, 1);
            if (poke && cyc == 3) begin
                start = 1'b1;
                for (int r = 0; r < ROWS; r++) act_v[r] = WS'($urandom);
                act_in    = pack_acts();
                fault_we  = 1'b1;
                fault_row = 2'd0;
                fault_col = 2'd0;
            end else begin
                start    = 1'b0;
                fault_we = 1'b0;
            end
            if (issue_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (q.size() == 0) begin
                    check("unexpected_job", 1, 0);
                end else begin
                    check("job_row", faultyRowOut, 64'(1) << q[0].r);
                    check("job_col", faultyColOut, 64'(1) << q[0].c);
                    check("job_weight", WeightOut, q[0].w);
                    check("job_left", LeftOut, q[0].a);
                end
                if (stall_left > 0) begin
                    issue_ready = 1'b0;
                    stall_left--;
                    stalls++;
                end else begin
                    issue_ready = 1'b1;
                    jobs++;
                    if (q.size() > 0) begin
                        last      = q.pop_front();
                        have_last = 1;
                    end
                    stall_left = (stall_mode >= 0) ? stall_mode : int'($urandom_range(0, 3));
                end
            end else begin
                issue_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        start       = 1'b0;
        fault_we    = 1'b0;
        issue_ready = 1'b0;
        if (poke) mdl_f[0][0] = 1'b1;
        check("done_seen", seen_done, 1);
        check("pass_len", cyc, CELLS + jobs + stalls + 1);
        check("jobs_left", q.size(), 0);
        if (first_idx >= 0) check("first_job_latency", first_valid, first_idx + 2);
        else check("no_job_issued", first_valid, -1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_not_busy", busy, 0);
        check("idle_not_valid", issue_valid, 0);
        if (have_last) begin
            check("hold_row", faultyRowOut, 64'(1) << last.r);
            check("hold_weight", WeightOut, last.w);
            check("hold_left", LeftOut, last.a);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, issue_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_row"}, faultyRowOut, 0);
        check({tag, "_col"}, faultyColOut, 0);
        check({tag, "_weight"}, WeightOut, 0);
        check({tag, "_left"}, LeftOut, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   cnt;
        bit   any_done;
        rst         = 1'b1;
        fault_we    = 1'b0;
        fault_row   = '0;
        fault_col   = '0;
        map_clear   = 1'b0;
        weight_we   = 1'b0;
        weight_data = '0;
        start       = 1'b0;
        issue_ready = 1'b0;
        for (int r = 0; r < ROWS; r++) act_v[r] = '0;
        act_in = pack_acts();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("reset");
`ifdef FAULT_COUNT_EN
        check("reset_count", fault_count, 0);
`endif

        // Empty map: done exactly CELLS+1 cycles after start.
        run_pass(0, 0);

        // Single fault at (1,1).
        map_write(1, 0, 1, 1, 1, 16'd3);
        act_v[0] = 16'd1; act_v[1] = 16'd4; act_v[2] = 16'd9;
        run_pass(0, 0);
        check("single_row", faultyRowOut, 3'b010);
        check("single_col", faultyColOut, 3'b010);
        check("single_weight", WeightOut, 16'd3);
        check("single_left", LeftOut, 16'd4);

        // Two faults with a 3-cycle stall each.
        map_write(0, 1, 0, 0, 0, 16'd0);
        map_write(1, 0, 1, 0, 2, 16'd7);
        map_write(1, 0, 1, 2, 1, 16'd10);
        act_v[0] = 16'd8; act_v[1] = 16'd0; act_v[2] = 16'd20;
        run_pass(3, 0);

        // start and act_in changes mid-pass are ignored; a late write to (0,0) waits for the next pass.
        act_v[0] = 16'h1111; act_v[1] = 16'h2222; act_v[2] = 16'h3333;
        run_pass(1, 1);
        run_pass(0, 0);

        // Out-of-range writes are ignored.
        map_write(0, 1, 0, 0, 0, 16'd0);
        map_write(1, 0, 1, 3, 1, 16'hdead);
        map_write(1, 0, 1, 1, 3, 16'hbeef);
        run_pass(0, 0);

        // Clear wins over a same-cycle set.
        map_write(1, 0, 1, 2, 2, 16'd5);
        map_write(1, 1, 0, 1, 0, 16'd0);
        run_pass(0, 0);

        // Last-cell fault exercises ISSUE -> DONE.
        map_write(1, 0, 1, 2, 2, 16'h00aa);
        run_pass(2, 0);

        // Randomized passes.
        for (int it = 0; it < 8; it++) begin
            int nw;
            if ($urandom_range(0, 3) == 0) map_write(0, 1, 0, 0, 0, 16'd0);
            nw = int'($urandom_range(0, 4));
            for (int k = 0; k < nw; k++)
                map_write(1, 0, 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), WS'($urandom));
            for (int r = 0; r < ROWS; r++) act_v[r] = WS'($urandom);
`ifdef FAULT_COUNT_EN
            check("rand_count", fault_count, model_count());
`endif
            run_pass(-1, 0);
        end

`ifdef FAULT_COUNT_EN
        map_write(0, 1, 0, 0, 0, 16'd0);
        map_write(1, 0, 0, 0, 1, 16'd0);
        map_write(1, 0, 0, 1, 2, 16'd0);
        map_write(1, 0, 0, 2, 0, 16'd0);
        map_write(1, 0, 0, 1, 2, 16'd0);
        check("count_three", fault_count, 3);
        check("count_model", fault_count, model_count());
        map_write(0, 1, 0, 0, 0, 16'd0);
        check("count_clear", fault_count, 0);
`endif

        // Reset during ISSUE aborts the pass with no done pulse.
        map_write(1, 0, 1, 1, 0, 16'd5);
        act_v[1] = 16'd6;
        act_in = pack_acts();
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!issue_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("reached_issue", issue_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int r = 0; r < ROWS; r++) act_v[r] = '0;
        check_zero_outputs("abort");
        any_done = 0;
        issue_ready = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) any_done = 1;
        end
        issue_ready = 1'b0;
        check("abort_no_done", any_done, 0);
`ifdef FAULT_COUNT_EN
        check("abort_count", fault_count, 0);
`endif
        // Map was wiped by reset, so the next pass is empty.
        run_pass(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/recompute_dispatcher.md
Name: recompute_dispatcher

Overview:
Upstream feeder for the recompute unit in the BISR recompute path. Holds the fault map of the ROWS x COLS systolic array, filled from BIST diagnosis, plus a shadow copy of each PE's weight. On start it walks the map in row-major order and issues one recompute job per faulty PE: one-hot faulty row/col, that PE's weight, and the row's activation (LeftIn). Jobs go out through a valid/ready handshake.

Parameters:
ROWS, 3, systolic array rows
COLS, 3, systolic array columns
WORD_SIZE, 16, data width of weights and activations

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fault_we  in  1  set fault bit at (fault_row, fault_col)
fault_row  in  $clog2(ROWS)  binary row index of reported fault
fault_col  in  $clog2(COLS)  binary col index of reported fault
map_clear  in  1  clear whole fault map
weight_we  in  1  write weight_data into shadow weight at (fault_row, fault_col)
weight_data  in  WORD_SIZE  weight value
act_in  in  ROWS*WORD_SIZE  per-row activations, row r at [r*WORD_SIZE +: WORD_SIZE]
start  in  1  begin dispatch pass (pulse)
issue_ready  in  1  downstream accepts current job
issue_valid  out  1  job presented
faultyRowOut  out  ROWS  one-hot row of faulty PE
faultyColOut  out  COLS  one-hot col of faulty PE
WeightOut  out  WORD_SIZE  shadow weight of that PE
LeftOut  out  WORD_SIZE  activation of that PE's row (captured at start)
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (clk edge with rst=1): state IDLE, fault map all 0, shadow weights 0, cell index 0, captured activations 0; issue_valid=0, busy=0, done=0, faultyRowOut=0, faultyColOut=0, WeightOut=0, LeftOut=0. rst mid-pass aborts the pass; no done pulse.
- Map writes: fault_we sets bit next cycle; map_clear wins over fault_we in the same cycle. Writes are accepted in any state; a bit for a cell already scanned in the current pass takes effect on the next pass. Out-of-range indices are ignored.
- FSM IDLE -> SCAN -> (ISSUE) -> DONE -> IDLE:
  IDLE: start=1 captures act_in and sets idx=0, then goes to SCAN; busy=1 from the next cycle. start in any other state is ignored.
  SCAN: examines cell idx (row = idx/COLS, col = idx%COLS), one cell per cycle. If the cell is faulty, load the output registers and go to ISSUE. If it is healthy and the last cell, go to DONE; otherwise idx++.
  ISSUE: issue_valid=1 and outputs stay stable until issue_ready=1 in the same cycle. On handshake: if last cell go to DONE, otherwise idx++ and go to SCAN. issue_valid drops the cycle after the handshake.
  DONE: done=1 for one cycle, busy=0 next cycle, then IDLE.
- Timing: the first job is visible 2 cycles after start for fault (0,0). A pass takes ROWS*COLS scan cycles + 1 per fault + stall cycles + 1 DONE cycle. An empty map gives done exactly ROWS*COLS+1 cycles after start.
- Outputs other than done hold their last job value outside ISSUE. issue_ready outside ISSUE has no effect.

Optional Feature:
FAULT_COUNT_EN: when defined, adds output fault_count ($clog2(ROWS*COLS+1) bits), the popcount of the fault map. It is registered, updates the cycle after any map write, and resets to 0. When undefined, the port and its logic are absent.

Decomposition:
- Shared package bisr_pkg: dispatch state enum (IDLE, SCAN, ISSUE, DONE) and index-width localparams.
- Sub-module fault_map_regfile: fault bitmap plus shadow weight storage, with write/clear ports and a read by idx. The FSM lives in the top module.

Test Plan:
- Reset, no faults, start -> no issue_valid; done pulses exactly 10 cycles after start (3x3); busy high in between.
- fault_we (1,1), weight_we (1,1)=3, act_in row1=4, start, ready held 1 -> one job: faultyRowOut=3'b010, faultyColOut=3'b010, WeightOut=3, LeftOut=4; then done.
- Faults (0,2) and (2,1) with weights 7/10, acts 8/20, ready held 0 for 3 cycles then 1 -> jobs in order (0,2) then (2,1), outputs stable during stall.
- start pulsed while busy, and act_in changed mid-pass -> ignored; LeftOut uses the values captured at start.
- map_clear and fault_we in the same cycle, then start -> empty pass. rst asserted during ISSUE -> all outputs 0 next cycle, no done pulse.
- With FAULT_COUNT_EN: 3 distinct faults written, 1 duplicate -> fault_count=3; after map_clear -> 0.
